// File: rtl/prefix_pkg.sv
// Shared kill/generate/propagate encoding and prefix-combine helpers used by the
// Kogge-Stone add and subtract paths.
package prefix_pkg;

   typedef logic [1:0] kgp_t;

   localparam kgp_t KGP_K = 2'b00;
   localparam kgp_t KGP_P = 2'b01;
   localparam kgp_t KGP_G = 2'b11;

   // Per-bit encoding of operand bits x, y: K if both 0, G if both 1, else P.
   function automatic kgp_t kgp_encode(input logic x, input logic y);
      kgp_t r;
      if (x && y)
         r = KGP_G;
      else if (x || y)
         r = KGP_P;
      else
         r = KGP_K;
      return r;
   endfunction

   // A resolved upper group (K or G) wins; a propagating one defers to the lower group.
   function automatic kgp_t kgp_combine(input kgp_t hi, input kgp_t lo);
      return (hi == KGP_P) ? lo : hi;
   endfunction

endpackage

// File: rtl/prefix_sub_level.sv
// One Kogge-Stone prefix level of span SPAN over a packed 2-bit-per-position kgp vector.
module prefix_sub_level
   import prefix_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SPAN  = 1
) (
   input  logic [2*WIDTH-1:0] i_kgp,
   output logic [2*WIDTH-1:0] o_kgp
);

   localparam int NPOS = int'(WIDTH);
   localparam int SP   = int'(SPAN);

   genvar gi;
   generate
      for (gi = 0; gi < NPOS; gi++) begin : g_pos
         if (gi >= SP) begin : g_comb
            assign o_kgp[2*gi +: 2] = kgp_combine(i_kgp[2*gi +: 2], i_kgp[2*(gi-SP) +: 2]);
         end else begin : g_pass
            assign o_kgp[2*gi +: 2] = i_kgp[2*gi +: 2];
         end
      end
   endgenerate

endmodule

// File: rtl/prefix_sub_pipe.sv
// 4-stage pipelined Kogge-Stone subtractor (a - b - borrow_in) with valid/ready.
// Compare flags (eq, lt_u, lt_s) are built only when PREFIX_SUB_FLAGS_EN is defined.
module prefix_sub_pipe #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             eq,
   output logic             lt_u,
   output logic             lt_s
);
   import prefix_pkg::*;

   localparam int unsigned KW  = 2 * WIDTH;
   localparam int unsigned MSB = WIDTH - 1;

   logic             w_advance;
   logic [KW-1:0]    w_kgp0, w_l1, w_l2, w_l3, w_l4, w_l5;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH:0]   w_c;
   logic [WIDTH-1:0] w_diff;
   logic             w_borrow, w_ovf;

   logic             r_s1_valid, r_s2_valid, r_s3_valid, r_out_valid;
   logic [KW-1:0]    r_s1_kgp, r_s2_kgp, r_s3_kgp;
   logic [WIDTH-1:0] r_s1_p, r_s2_p, r_s3_p;
   logic             r_s1_cin, r_s2_cin, r_s3_cin;
   logic             r_s1_amsb, r_s2_amsb, r_s3_amsb;
   logic             r_s1_nbmsb, r_s2_nbmsb, r_s3_nbmsb;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow, r_ovf;

   assign w_advance = !r_out_valid || out_ready;
   assign in_ready  = w_advance;

   // Encode a + ~b and fold the carry-in (~borrow_in) into position 0.
   always_comb begin
      w_kgp0 = '0;
      for (int i = 0; i < int'(WIDTH); i++)
         w_kgp0[2*i +: 2] = kgp_encode(a[i], ~b[i]);
      if (w_kgp0[1:0] == KGP_P)
         w_kgp0[1:0] = borrow_in ? KGP_K : KGP_G;
   end

   assign w_p = a ^ ~b;

   prefix_sub_level #(.WIDTH(WIDTH), .SPAN(1))  u_lvl1 (.i_kgp(r_s1_kgp), .o_kgp(w_l1));
   prefix_sub_level #(.WIDTH(WIDTH), .SPAN(2))  u_lvl2 (.i_kgp(w_l1),     .o_kgp(w_l2));
   prefix_sub_level #(.WIDTH(WIDTH), .SPAN(4))  u_lvl3 (.i_kgp(r_s2_kgp), .o_kgp(w_l3));
   prefix_sub_level #(.WIDTH(WIDTH), .SPAN(8))  u_lvl4 (.i_kgp(w_l3),     .o_kgp(w_l4));
   prefix_sub_level #(.WIDTH(WIDTH), .SPAN(16)) u_lvl5 (.i_kgp(r_s3_kgp), .o_kgp(w_l5));

   // After the last level every prefix is resolved, so carry into i is prefix[i-1]==G.
   always_comb begin
      w_c    = '0;
      w_c[0] = r_s3_cin;
      for (int i = 1; i <= int'(WIDTH); i++)
         w_c[i] = (w_l5[2*(i-1) +: 2] == KGP_G);
   end

   assign w_diff   = r_s3_p ^ w_c[WIDTH-1:0];
   assign w_borrow = ~w_c[WIDTH];
   assign w_ovf    = (r_s3_amsb == r_s3_nbmsb) && (w_diff[MSB] != r_s3_amsb);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_s1_valid  <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_s3_valid  <= 1'b0;
         r_out_valid <= 1'b0;
         r_s1_kgp    <= '0;
         r_s2_kgp    <= '0;
         r_s3_kgp    <= '0;
         r_s1_p      <= '0;
         r_s2_p      <= '0;
         r_s3_p      <= '0;
         r_s1_cin    <= 1'b0;
         r_s2_cin    <= 1'b0;
         r_s3_cin    <= 1'b0;
         r_s1_amsb   <= 1'b0;
         r_s2_amsb   <= 1'b0;
         r_s3_amsb   <= 1'b0;
         r_s1_nbmsb  <= 1'b0;
         r_s2_nbmsb  <= 1'b0;
         r_s3_nbmsb  <= 1'b0;
         r_diff      <= '0;
         r_borrow    <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_advance) begin
         r_s1_valid  <= in_valid;
         r_s1_kgp    <= w_kgp0;
         r_s1_p      <= w_p;
         r_s1_cin    <= ~borrow_in;
         r_s1_amsb   <= a[MSB];
         r_s1_nbmsb  <= ~b[MSB];
         r_s2_valid  <= r_s1_valid;
         r_s2_kgp    <= w_l2;
         r_s2_p      <= r_s1_p;
         r_s2_cin    <= r_s1_cin;
         r_s2_amsb   <= r_s1_amsb;
         r_s2_nbmsb  <= r_s1_nbmsb;
         r_s3_valid  <= r_s2_valid;
         r_s3_kgp    <= w_l4;
         r_s3_p      <= r_s2_p;
         r_s3_cin    <= r_s2_cin;
         r_s3_amsb   <= r_s2_amsb;
         r_s3_nbmsb  <= r_s2_nbmsb;
         r_out_valid <= r_s3_valid;
         r_diff      <= w_diff;
         r_borrow    <= w_borrow;
         r_ovf       <= w_ovf;
      end
   end

   assign out_valid  = r_out_valid;
   assign diff       = r_diff;
   assign borrow_out = r_borrow;
   assign overflow   = r_ovf;

`ifdef PREFIX_SUB_FLAGS_EN
   logic r_eq, r_lt_u, r_lt_s;

   // Equality needs no borrow-in; r_s3_cin is the inverted borrow_in of this op.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_eq   <= 1'b0;
         r_lt_u <= 1'b0;
         r_lt_s <= 1'b0;
      end else if (w_advance) begin
         r_eq   <= (w_diff == '0) && r_s3_cin;
         r_lt_u <= w_borrow;
         r_lt_s <= w_diff[MSB] ^ w_ovf;
      end
   end

   assign eq   = r_eq;
   assign lt_u = r_lt_u;
   assign lt_s = r_lt_s;
`else
   assign eq   = 1'b0;
   assign lt_u = 1'b0;
   assign lt_s = 1'b0;
`endif

endmodule

// File: tb/tb_prefix_sub_pipe.sv
// Scoreboard bench for prefix_sub_pipe: directed vectors with hand-computed results.
module tb_prefix_sub_pipe;

   typedef struct {
      logic [31:0] diff;
      logic        bo;
      logic        ov;
      logic        eq;
      logic        ltu;
      logic        lts;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        borrow_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        borrow_out;
   logic        overflow;
   logic        eq;
   logic        lt_u;
   logic        lt_s;

   exp_t        q[$];
   exp_t        e;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_results = 0;
   int          n_seen_after_reset = 0;
   int          stall_cnt = 0;
   int          stall_left = 0;
   bit          stall_arm = 1'b0;
   bit          stall_window = 1'b0;
   bit          watch_reset = 1'b0;
   bit          prev_stalled = 1'b0;
   logic [31:0] prev_diff = '0;

   prefix_sub_pipe #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow),
      .eq         (eq),
      .lt_u       (lt_u),
      .lt_s       (lt_s)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] d, input logic bo, input logic ov,
                               input logic feq, input logic fltu, input logic flts);
      exp_t r;
      r.diff = d;
      r.bo   = bo;
      r.ov   = ov;
`ifdef PREFIX_SUB_FLAGS_EN
      r.eq   = feq;
      r.ltu  = fltu;
      r.lts  = flts;
`else
      r.eq   = 1'b0;
      r.ltu  = 1'b0;
      r.lts  = 1'b0;
`endif
      return r;
   endfunction

   // Monitor: pops the scoreboard on every output transfer and checks hold during stalls.
   always @(negedge clk) begin
      #2;
      if (reset === 1'b1) begin
         if (prev_stalled)
            check("hold_diff", diff, prev_diff);
         if (stall_window && in_ready === 1'b0)
            stall_cnt++;
         if (watch_reset && out_valid === 1'b1)
            n_seen_after_reset++;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got diff 0x%08h, expected no result", diff);
            end else begin
               e = q.pop_front();
               check("diff",       diff,              e.diff);
               check("borrow_out", 32'(borrow_out),   32'(e.bo));
               check("overflow",   32'(overflow),     32'(e.ov));
               check("eq",         32'(eq),           32'(e.eq));
               check("lt_u",       32'(lt_u),         32'(e.ltu));
               check("lt_s",       32'(lt_s),         32'(e.lts));
               n_results++;
            end
         end
         prev_stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
         prev_diff    = diff;
      end else begin
         prev_stalled = 1'b0;
      end
   end

   // Back-pressure generator: out_ready low for 3 cycles once a result appears.
   always @(negedge clk) begin
      if (stall_left > 0) begin
         stall_left--;
         if (stall_left == 0)
            out_ready = 1'b1;
      end else if (stall_arm && out_valid === 1'b1) begin
         out_ready  = 1'b0;
         stall_left = 3;
         stall_arm  = 1'b0;
      end
   end

   task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                       input exp_t ex);
      int guard = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      a         = ta;
      b         = tb;
      borrow_in = tbin;
      #1;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (in_ready !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
         in_valid = 1'b0;
      end else begin
         q.push_back(ex);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int guard = 0;
      while (q.size() != 0 && guard < 100) begin
         @(posedge clk);
         guard++;
      end
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
         q.delete();
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      borrow_in = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff",      diff,           32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);

      send(32'd5, 32'd3, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drain();
      send(32'd0, 32'd1, 1'b0, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
      send(32'h8000_0000, 32'd1, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      drain();
      send(32'd10, 32'd9, 1'b1, mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      send(32'd0, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
      send(32'd7, 32'd7, 1'b0, mk(32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      send(32'd1, 32'hFFFF_FFFF, 1'b0, mk(32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      drain();
      check("count_basic", 32'(n_results), 32'd7);

      // Four back-to-back ops with a 3-cycle output stall.
      stall_cnt    = 0;
      stall_arm    = 1'b1;
      stall_window = 1'b1;
      send(32'd100, 32'd50, 1'b0, mk(32'h0000_0032, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, mk(32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      send(32'h1234_5678, 32'h1234_5678, 1'b1, mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
      send(32'hFFFF_FFFF, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      drain();
      stall_window = 1'b0;
      check("stall_cycles", 32'(stall_cnt), 32'd3);
      check("count_stall",  32'(n_results), 32'd11);

      // Abort an in-flight op with a one-cycle reset.
      send(32'd3, 32'd1, 1'b0, mk(32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_out_valid",  32'(out_valid),  32'd0);
      check("abort_diff",       diff,            32'd0);
      check("abort_borrow_out", 32'(borrow_out), 32'd0);
      check("abort_overflow",   32'(overflow),   32'd0);
      check("abort_eq",         32'(eq),         32'd0);
      check("abort_lt_u",       32'(lt_u),       32'd0);
      check("abort_lt_s",       32'(lt_s),       32'd0);
      watch_reset = 1'b1;
      repeat (10) @(posedge clk);
      watch_reset = 1'b0;
      check("abort_no_result", 32'(n_seen_after_reset), 32'd0);

      send(32'd9, 32'd4, 1'b0, mk(32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      drain();
      check("count_total", 32'(n_results), 32'd12);
      check("queue_empty", 32'(q.size()),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/prefix_sub_pipe.md
Name: prefix_sub_pipe

Overview:
- Pipelined WIDTH-bit parallel-prefix (Kogge-Stone) subtractor with valid/ready handshake on both sides.
- Computes a - b - borrow_in as a + ~b + ~borrow_in, using the same 2-bit kill/generate/propagate (kgp) encoding and 5-level prefix tree as the add path.
- Sits beside the adder in the ALU slot of the VLIW datapath and gives the issue stage a subtract/compare unit.
- Fixed latency: 4 cycles from input accept to result valid.

Parameters:
- WIDTH, 32, operand width; must be 32. kgp vectors are 2*WIDTH = 64 bits, and the prefix tree has log2(WIDTH) = 5 levels.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit can accept operands this cycle.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- borrow_in  in  1  borrow into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  a - b - borrow_in, modulo 2^WIDTH.
- borrow_out  out  1  unsigned borrow; equals inverted carry-out.
- overflow  out  1  signed overflow.
- eq  out  1  a == b (flags feature only).
- lt_u  out  1  a < b, unsigned (flags feature only).
- lt_s  out  1  a < b, signed (flags feature only).

Behaviour:
- kgp encoding per bit: K=2'b00, P=2'b01, G=2'b11. Bit i of x = a[i], y = ~b[i]: K if both 0, G if both 1, P otherwise. 2'b10 is never produced.
- Carry-in ~borrow_in is folded into bit 0 before level 1: bit 0 becomes G if carry-in=1 and bit 0 is P, K if carry-in=0 and bit 0 is P.
- Prefix combine at span s for position i >= s: (hi, lo) -> hi if hi is K or G, else lo. Positions i < s pass through.
- Pipeline:
  - S1 registers kgp, a[msb], ~b[msb], the raw operands (flags feature only), and valid.
  - S2 registers the result of levels 1-2 (spans 1, 2).
  - S3 registers levels 3-4 (spans 4, 8).
  - S4 applies level 5 (span 16), then forms sum, borrow, and flags into output registers.
- Sum: diff[i] = p[i] XOR c[i], where p[i] = a[i]^~b[i], c[0] = ~borrow_in, and c[i] = 1 iff prefix[i-1] is G.
- borrow_out = ~c[WIDTH]. overflow = (a[msb] != b[msb]) && (diff[msb] != a[msb]).
- Handshake and stall:
  - advance = !out_valid || out_ready.
  - All stages shift only when advance=1; in_ready = advance, combinational.
  - An input transfer occurs when in_valid && in_ready. Bubbles are carried as valid=0 and are not collapsed.
  - While out_valid=1 && out_ready=0, diff and flags hold stable.
- Reset (reset==0 at an edge): all stage valids and out_valid go to 0; diff, borrow_out, overflow, eq, lt_u, lt_s go to 0.
  - Mid-flight operations are discarded; no stale result may appear after reset deasserts.
- Latency: an operation accepted at edge N presents out_valid at edge N+4 when there is no stall. Each cycle of stall adds one cycle.
- Results emerge in acceptance order, exactly once each.

Optional Feature:
- Macro: PREFIX_SUB_FLAGS_EN.
- Defined: eq = (diff==0 && borrow_in==0 of that op), lt_u = borrow_out, lt_s = diff[msb] XOR overflow; all three are registered alongside diff.
- Not defined: eq, lt_u, lt_s are tied to 0, and operand copies are not carried through the pipe.

Decomposition:
- Shared package prefix_pkg:
  - KGP_K, KGP_P, KGP_G constants.
  - kgp_t 2-bit typedef.
  - A combine function used by both add and subtract paths.
- One sub-module, prefix_sub_level: one Kogge-Stone level, parameterised by SPAN; combinational on a 2*WIDTH kgp vector. Instantiated 5 times.

Test Plan:
- a=5, b=3, borrow_in=0, out_ready=1 -> 4 cycles later: diff=0x00000002, borrow_out=0, overflow=0.
- a=0, b=1 -> diff=0xFFFFFFFF, borrow_out=1, overflow=0. Then a=0x80000000, b=1 -> diff=0x7FFFFFFF, overflow=1, borrow_out=0.
- Four back-to-back ops; out_ready low for 3 cycles once the first result appears -> in_ready low for exactly those cycles, diff held stable, all four results in order with none lost or duplicated.
- Accept an op, pull reset low on the 2nd cycle for 1 cycle -> out_valid=0 and all outputs 0 after the reset edge; no result for the aborted op ever appears.
- a=10, b=9, borrow_in=1 -> diff=0, borrow_out=0. Then a=0, b=0, borrow_in=1 -> diff=0xFFFFFFFF, borrow_out=1.
- With PREFIX_SUB_FLAGS_EN:
  - a=7, b=7 -> eq=1, lt_u=0, lt_s=0.
  - a=1, b=0xFFFFFFFF -> lt_u=1, lt_s=0, eq=0.
